// File: rtl/dds_multi_core.sv
// Multi-channel DDS: per-channel phase accumulators with shadow/active register banks,
// a global coherent update strobe, linear frequency sweep and saturating gain/offset.
module dds_multi_core #(
    parameter int NUM_CH    = 2,
    parameter int ACC_W     = 28,
    parameter int PHASE_W   = 12,
    parameter int OUT_W     = 8,
    parameter int SWEEP_DIV = 256,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [2:0]              wr_addr,
    input  logic [ACC_W-1:0]        wr_data,
    input  logic                    update,
    output logic [NUM_CH*OUT_W-1:0] dds_output,
    output logic [NUM_CH-1:0]       wrap
);
    localparam int CNT_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

    logic [ACC_W-1:0]   sh_freq_q  [NUM_CH];
    logic [ACC_W-1:0]   sh_freq_d  [NUM_CH];
    logic [PHASE_W-1:0] sh_phase_q [NUM_CH];
    logic [PHASE_W-1:0] sh_phase_d [NUM_CH];
    logic [1:0]         sh_mode_q  [NUM_CH];
    logic [1:0]         sh_mode_d  [NUM_CH];
    logic [7:0]         sh_gain_q  [NUM_CH];
    logic [7:0]         sh_gain_d  [NUM_CH];
    logic [OUT_W-1:0]   sh_off_q   [NUM_CH];
    logic [OUT_W-1:0]   sh_off_d   [NUM_CH];
    logic [ACC_W-1:0]   sh_step_q  [NUM_CH];
    logic [ACC_W-1:0]   sh_step_d  [NUM_CH];
    logic [ACC_W-1:0]   sh_lim_q   [NUM_CH];
    logic [ACC_W-1:0]   sh_lim_d   [NUM_CH];
    logic               sh_en_q    [NUM_CH];
    logic               sh_en_d    [NUM_CH];
    logic               sh_clr_q   [NUM_CH];
    logic               sh_clr_d   [NUM_CH];

    logic [ACC_W-1:0]   act_freq_q  [NUM_CH];
    logic [PHASE_W-1:0] act_phase_q [NUM_CH];
    logic [1:0]         act_mode_q  [NUM_CH];
    logic [7:0]         act_gain_q  [NUM_CH];
    logic [OUT_W-1:0]   act_off_q   [NUM_CH];
    logic [ACC_W-1:0]   act_step_q  [NUM_CH];
    logic [ACC_W-1:0]   act_lim_q   [NUM_CH];
    logic               act_en_q    [NUM_CH];
    logic [ACC_W-1:0]   start_q     [NUM_CH];

    logic [ACC_W-1:0]   acc_q      [NUM_CH];
    logic [ACC_W:0]     acc_sum    [NUM_CH];
    logic [ACC_W:0]     sweep_sum  [NUM_CH];
    logic [PHASE_W-1:0] phase_p0   [NUM_CH];
    logic [OUT_W-1:0]   wave_p0    [NUM_CH];
    logic [OUT_W-1:0]   wave_p1_q  [NUM_CH];
    logic [NUM_CH*OUT_W-1:0] out_p2_q;
    logic [NUM_CH-1:0]  wrap_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               tick;

    function automatic logic [OUT_W-1:0] wave_f(input logic [PHASE_W-1:0] p, input logic [1:0] mode);
        logic [OUT_W-1:0] tri_w;
        tri_w = p[PHASE_W-2 -: OUT_W];
        case (mode)
            2'd0:    return p[PHASE_W-1 -: OUT_W];
            2'd1:    return p[PHASE_W-1] ? ~tri_w : tri_w;
            2'd2:    return {OUT_W{p[PHASE_W-1]}};
            default: return '0;
        endcase
    endfunction

    // gain is unsigned Q1.7, so 128 passes the wave through unchanged
    function automatic logic [OUT_W-1:0] scale_sat(input logic [OUT_W-1:0] w, input logic [7:0] g,
                                                   input logic [OUT_W-1:0] off);
        logic [OUT_W+7:0] prod;
        logic [OUT_W+8:0] sum;
        prod = (OUT_W+8)'(w) * (OUT_W+8)'(g);
        sum  = (OUT_W+9)'(prod >> 7) + (OUT_W+9)'(off);
        if (sum > (OUT_W+9)'({OUT_W{1'b1}})) return '1;
        return sum[OUT_W-1:0];
    endfunction

    assign tick = (cnt_q == CNT_W'(SWEEP_DIV - 1));

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sh_freq_d[k]  = sh_freq_q[k];
            sh_phase_d[k] = sh_phase_q[k];
            sh_mode_d[k]  = sh_mode_q[k];
            sh_gain_d[k]  = sh_gain_q[k];
            sh_off_d[k]   = sh_off_q[k];
            sh_step_d[k]  = sh_step_q[k];
            sh_lim_d[k]   = sh_lim_q[k];
            sh_en_d[k]    = sh_en_q[k];
            sh_clr_d[k]   = sh_clr_q[k];
            // out-of-range channel numbers never match any k, so they are dropped
            if (wr_en && (int'(wr_ch) == k)) begin
                case (wr_addr)
                    3'd0:    sh_freq_d[k]  = wr_data;
                    3'd1:    sh_phase_d[k] = wr_data[PHASE_W-1:0];
                    3'd2:    sh_mode_d[k]  = wr_data[1:0];
                    3'd3:    sh_gain_d[k]  = wr_data[7:0];
                    3'd4:    sh_off_d[k]   = wr_data[OUT_W-1:0];
                    3'd5:    sh_step_d[k]  = wr_data;
                    3'd6:    sh_lim_d[k]   = wr_data;
                    default: begin
                        sh_en_d[k]  = wr_data[0];
                        sh_clr_d[k] = wr_data[1];
                    end
                endcase
            end
            acc_sum[k]   = {1'b0, acc_q[k]} + {1'b0, act_freq_q[k]};
            sweep_sum[k] = {1'b0, act_freq_q[k]} + {1'b0, act_step_q[k]};
            phase_p0[k]  = acc_q[k][ACC_W-1 -: PHASE_W] + act_phase_q[k];
            wave_p0[k]   = wave_f(phase_p0[k], act_mode_q[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            out_p2_q <= '0;
            wrap_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                sh_freq_q[k]   <= '0;
                sh_phase_q[k]  <= '0;
                sh_mode_q[k]   <= '0;
                sh_gain_q[k]   <= 8'd128;
                sh_off_q[k]    <= '0;
                sh_step_q[k]   <= '0;
                sh_lim_q[k]    <= '0;
                sh_en_q[k]     <= 1'b0;
                sh_clr_q[k]    <= 1'b0;
                act_freq_q[k]  <= '0;
                act_phase_q[k] <= '0;
                act_mode_q[k]  <= '0;
                act_gain_q[k]  <= 8'd128;
                act_off_q[k]   <= '0;
                act_step_q[k]  <= '0;
                act_lim_q[k]   <= '0;
                act_en_q[k]    <= 1'b0;
                start_q[k]     <= '0;
                acc_q[k]       <= '0;
                wave_p1_q[k]   <= '0;
            end
        end else begin
            cnt_q <= (update || tick) ? '0 : cnt_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                sh_freq_q[k]  <= sh_freq_d[k];
                sh_phase_q[k] <= sh_phase_d[k];
                sh_mode_q[k]  <= sh_mode_d[k];
                sh_gain_q[k]  <= sh_gain_d[k];
                sh_off_q[k]   <= sh_off_d[k];
                sh_step_q[k]  <= sh_step_d[k];
                sh_lim_q[k]   <= sh_lim_d[k];
                sh_en_q[k]    <= sh_en_d[k];
                sh_clr_q[k]   <= sh_clr_d[k] && !update;

                if (update && sh_clr_d[k]) begin
                    acc_q[k]  <= '0;
                    wrap_q[k] <= 1'b0;
                end else begin
                    acc_q[k]  <= acc_sum[k][ACC_W-1:0];
                    wrap_q[k] <= acc_sum[k][ACC_W];
                end

                // update takes priority over a coincident sweep tick
                if (update) begin
                    act_freq_q[k]  <= sh_freq_d[k];
                    act_phase_q[k] <= sh_phase_d[k];
                    act_mode_q[k]  <= sh_mode_d[k];
                    act_gain_q[k]  <= sh_gain_d[k];
                    act_off_q[k]   <= sh_off_d[k];
                    act_step_q[k]  <= sh_step_d[k];
                    act_lim_q[k]   <= sh_lim_d[k];
                    act_en_q[k]    <= sh_en_d[k];
                    start_q[k]     <= sh_freq_d[k];
                end else if (tick && act_en_q[k]) begin
                    act_freq_q[k] <= (sweep_sum[k] > {1'b0, act_lim_q[k]}) ? start_q[k]
                                                                          : sweep_sum[k][ACC_W-1:0];
                end

                // stage 1: wave register
                wave_p1_q[k] <= wave_p0[k];
                // stage 2: scaled sample register
                out_p2_q[k*OUT_W +: OUT_W] <= scale_sat(wave_p1_q[k], act_gain_q[k], act_off_q[k]);
            end
        end
    end

    assign dds_output = out_p2_q;
    assign wrap       = wrap_q;
endmodule

// File: tb/tb_dds_multi_core.sv
// Self-checking bench for dds_multi_core: directed scenarios plus random register traffic,
// compared every cycle against a register-map level reference model.
module tb_dds_multi_core;
    localparam int NCH  = 3;
    localparam int ACCW = 28;
    localparam int PHW  = 12;
    localparam int OUTW = 8;
    localparam int DIV  = 4;
    localparam int CHW  = 2;
    localparam longint MOD  = 64'd1 << ACCW;
    localparam int OMAX = (1 << OUTW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic update = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [2:0] wr_addr = '0;
    logic [ACCW-1:0] wr_data = '0;
    logic [NCH*OUTW-1:0] dds_output;
    logic [NCH-1:0] wrap;

    dds_multi_core #(.NUM_CH(NCH), .ACC_W(ACCW), .PHASE_W(PHW), .OUT_W(OUTW), .SWEEP_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .update(update), .dds_output(dds_output), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: register file indexed by address, plus accumulator and sample history.
    longint sh  [NCH][8];
    longint act [NCH][8];
    longint start_f [NCH];
    longint acc [NCH];
    int wave_r [NCH];
    int out_r  [NCH];
    int wrap_r [NCH];
    int cnt;

    function automatic int reg_width(input int addr);
        case (addr)
            0, 5, 6: return ACCW;
            1:       return PHW;
            2:       return 2;
            3:       return 8;
            4:       return OUTW;
            default: return 2;
        endcase
    endfunction

    function automatic int wave_of(input longint a, input longint ph, input longint mode);
        int p, t;
        p = int'(((a >> (ACCW - PHW)) + ph) % (64'd1 << PHW));
        case (mode)
            0: return p >> (PHW - OUTW);
            1: begin
                t = (p % (1 << (PHW - 1))) >> (PHW - 1 - OUTW);
                return (p >= (1 << (PHW - 1))) ? OMAX - t : t;
            end
            2: return (p >= (1 << (PHW - 1))) ? OMAX : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int scale_of(input int w, input longint g, input longint o);
        longint v;
        v = (longint'(w) * g) / 128 + o;
        return (v > OMAX) ? OMAX : int'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            for (int a = 0; a < 8; a++) begin
                sh[k][a]  = 0;
                act[k][a] = 0;
            end
            sh[k][3] = 128;
            act[k][3] = 128;
            start_f[k] = 0;
            acc[k] = 0;
            wave_r[k] = 0;
            out_r[k] = 0;
            wrap_r[k] = 0;
        end
        cnt = 0;
    endtask

    task automatic model_step(input bit we, input int ch, input int addr, input longint data, input bit upd);
        bit tick;
        longint s, nf;
        tick = (cnt == DIV - 1);
        for (int k = 0; k < NCH; k++) begin
            out_r[k]  = scale_of(wave_r[k], act[k][3], act[k][4]);
            wave_r[k] = wave_of(acc[k], act[k][1], act[k][2]);
        end
        if (we && ch < NCH) sh[ch][addr] = data % (64'd1 << reg_width(addr));
        for (int k = 0; k < NCH; k++) begin
            s = acc[k] + act[k][0];
            if (upd && (sh[k][7] & 2) != 0) begin
                acc[k] = 0;
                wrap_r[k] = 0;
            end else begin
                acc[k] = s % MOD;
                wrap_r[k] = (s >= MOD) ? 1 : 0;
            end
        end
        if (upd) begin
            for (int k = 0; k < NCH; k++) begin
                for (int a = 0; a < 8; a++) act[k][a] = sh[k][a];
                start_f[k] = sh[k][0];
                sh[k][7] = sh[k][7] & 1;
            end
            cnt = 0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (tick && (act[k][7] & 1) != 0) begin
                    nf = act[k][0] + act[k][5];
                    act[k][0] = (nf > act[k][6]) ? start_f[k] : nf;
                end
            end
            cnt = tick ? 0 : cnt + 1;
        end
    endtask

    task automatic compare_model();
        logic [NCH*OUTW-1:0] e_out;
        logic [NCH-1:0] e_wrap;
        for (int k = 0; k < NCH; k++) begin
            e_out[k*OUTW +: OUTW] = OUTW'(out_r[k]);
            e_wrap[k] = wrap_r[k][0];
        end
        check_val("model_out", dds_output, e_out);
        check_val("model_wrap", wrap, e_wrap);
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks the result.
    task automatic cycle(input bit we, input int ch, input int addr, input longint data, input bit upd);
        wr_en = we;
        wr_ch = CHW'(ch);
        wr_addr = 3'(addr);
        wr_data = ACCW'(data);
        update = upd;
        @(posedge clk);
        model_step(we, ch, addr, data, upd);
        @(negedge clk);
        wr_en = 1'b0;
        update = 1'b0;
        compare_model();
    endtask

    task automatic wr(input int ch, input int addr, input longint data);
        cycle(1'b1, ch, addr, data, 1'b0);
    endtask

    task automatic upd();
        cycle(1'b0, 0, 0, 0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 1'b0);
    endtask

    function automatic int ch_out(input int k);
        return int'(dds_output[k*OUTW +: OUTW]);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        int sweep_exp [14] = '{0, 1, 2, 3, 4, 6, 8, 10, 12, 15, 18, 21, 24, 25};
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("reset_out", dds_output, 0);
        check_val("reset_wrap", wrap, 0);

        // sawtooth on ch0
        wr(0, 0, 'h1000000);
        upd();
        idle(2);
        for (int i = 0; i < 17; i++) begin
            check_val("saw_seq", ch_out(0), (i * 16) % 256);
            idle(1);
        end
        n = 0;
        for (int i = 0; i < 32; i++) begin
            idle(1);
            n += int'(wrap[0]);
        end
        check_val("wrap_count", n, 2);

        // shadow write without update, then coherent restart with phase offset
        wr(0, 0, 'h2000000);
        idle(20);
        wr(0, 0, 'h1000000);
        wr(1, 0, 'h1000000);
        wr(1, 1, 'h800);
        wr(0, 7, 2);
        wr(1, 7, 2);
        upd();
        idle(2);
        for (int i = 0; i < 16; i++) begin
            check_val("coh_ch0", ch_out(0), (i * 16) % 256);
            check_val("coh_ch1", ch_out(1), (i * 16 + 128) % 256);
            idle(1);
        end

        // asynchronous reset mid-run
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_out", dds_output, 0);
        check_val("async_rst_wrap", wrap, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(10);
        check_val("post_rst_ch0", ch_out(0), 0);

        // square with gain and offset saturation
        wr(0, 0, 'h1000000);
        wr(0, 2, 2);
        wr(0, 3, 255);
        wr(0, 4, 64);
        wr(0, 7, 2);
        upd();
        idle(2);
        for (int i = 0; i < 16; i++) begin
            check_val("square_sat", ch_out(0), (i < 8) ? 64 : 255);
            idle(1);
        end

        // triangle at unity gain
        wr(0, 2, 1);
        wr(0, 3, 128);
        wr(0, 4, 0);
        wr(0, 7, 2);
        upd();
        idle(2);
        for (int i = 0; i < 16; i++) begin
            check_val("triangle", ch_out(0), (i < 8) ? 32 * i : 255 - 32 * (i - 8));
            idle(1);
        end

        // frequency sweep
        wr(0, 0, 'h100000);
        wr(0, 5, 'h100000);
        wr(0, 6, 'h300000);
        wr(0, 2, 0);
        wr(0, 7, 3);
        upd();
        idle(2);
        for (int i = 0; i < 14; i++) begin
            check_val("sweep_seq", ch_out(0), sweep_exp[i]);
            idle(1);
        end
        guard = 0;
        while (cnt != DIV - 1 && guard < 2 * DIV) begin
            idle(1);
            guard++;
        end
        check_val("tick_align", cnt, DIV - 1);
        upd();
        idle(20);

        // randomized register traffic, including ignored channel and write-through updates
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) < 4)
                cycle(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      longint'($urandom) & (MOD - 1), ($urandom_range(0, 15) == 0));
            else
                cycle(1'b0, 0, 0, 0, ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/dds_multi_core.md
Name: dds_multi_core

Overview:
- Parametrised, multi-channel successor to the single-channel DDS path.
- NUM_CH independent phase-accumulator channels. Each channel has shadow/active double-buffered registers, a global phase-coherent update strobe, per-channel linear frequency sweep, and gain/offset with saturation.
- Register writes arrive on a simple write bus, driven by the SPI slave decoder.
- Outputs are the per-channel waveform samples, packed into one flat bus.

Parameters:
- NUM_CH, 2, number of DDS channels (1..8)
- ACC_W, 28, phase accumulator / frequency word width
- PHASE_W, 12, phase offset width and truncated phase width (PHASE_W >= OUT_W+1)
- OUT_W, 8, output sample width per channel
- SWEEP_DIV, 256, clocks between sweep steps (>= 1)
- Derived localparam: CH_W = max(1, clog2(NUM_CH)).

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous reset, active high
- wr_en, input, 1, register write strobe, one cycle
- wr_ch, input, CH_W, target channel
- wr_addr, input, 3, register address
- wr_data, input, ACC_W, write data, LSB-aligned
- update, input, 1, copy all shadow registers to active, all channels, same edge
- dds_output, output, NUM_CH*OUT_W, channel k at bits [k*OUT_W +: OUT_W]
- wrap, output, NUM_CH, one-cycle pulse on accumulator carry-out

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is asynchronous and active high. rst asynchronously clears everything and overrides all other inputs.
- Reset values:
  - all accumulators 0
  - dds_output 0, wrap 0
  - shadow and active: freq 0, phase 0, mode 0, gain 128, offset 0, sweep step 0, sweep limit 0, ctrl 0
  - sweep counter 0
- Register map (shadow, per channel). Unused high bits of wr_data are ignored.
  - 0 freq[ACC_W]
  - 1 phase[PHASE_W]
  - 2 mode[2]
  - 3 gain[8]
  - 4 offset[OUT_W]
  - 5 sweep_step[ACC_W]
  - 6 sweep_limit[ACC_W]
  - 7 ctrl: bit0 sweep_en, bit1 acc_clear (self-clearing after update)
- Write rules:
  - Writes with wr_ch >= NUM_CH are ignored.
  - A write changes only the shadow copy. Active values are untouched until update.
  - If wr_en and update are in the same cycle, the written value is included in that update (write-through).
- On update:
  - all active registers load from shadow on the same edge
  - sweep start register (per channel) = shadow freq
  - sweep counter cleared to 0
  - any channel with acc_clear=1 has its accumulator set to 0 on that edge, instead of adding
- Accumulator: acc <= acc + active_freq, mod 2^ACC_W, every cycle. wrap[k] is registered and high in the cycle following a carry-out.
- Phase: p = acc[ACC_W-1 -: PHASE_W] + active_phase, mod 2^PHASE_W.
- Wave, by mode:
  - 0 sawtooth: p[PHASE_W-1 -: OUT_W]
  - 1 triangle: p[PHASE_W-2 -: OUT_W], bitwise-inverted when p[PHASE_W-1]=1
  - 2 square: all-ones if p[PHASE_W-1], else 0
  - 3 off: 0
- Scaling: out = min(2^OUT_W-1, ((wave*gain) >> 7) + offset). Unsigned arithmetic with full-width intermediate; gain 128 is unity.
- Pipeline and latency:
  - stage 1 registers wave; stage 2 registers out into dds_output
  - dds_output reflects the accumulator value held 2 cycles earlier
  - register changes reach the output 3 cycles after update
- Sweep:
  - a shared counter counts 0..SWEEP_DIV-1; on terminal count it wraps and issues a tick
  - on tick, each channel with sweep_en: if active_freq + sweep_step > sweep_limit (compared in ACC_W+1 bits), active_freq <= sweep start; else active_freq <= active_freq + sweep_step
  - channels with sweep_en=0 keep active_freq constant
  - tick and update in the same cycle: update wins
- Reset mid-operation: all state cleared immediately. The first output after release is 0.

Test Plan:
- Assert rst mid-run with ch0 sawtooth active -> dds_output=0 and wrap=0 asynchronously (before next clk). After release, ch0 out stays 0 until an update.
- ch0 write freq=0x1000000, mode 0, then update -> dds_output[7:0] sequence 0,16,32,…,240,0 starting 3 cycles after update. wrap[0] pulses every 16 cycles.
- Write ch0 freq=0x2000000 with no update -> output period unchanged. Then ch0 and ch1 freq=0x1000000, ch1 phase=0x800, both ctrl.acc_clear=1, update -> ch1 out = (ch0 out + 128) mod 256 on every cycle.
- ch0 mode 2, gain 255, offset 64 -> high samples saturate to 255 (508+64 clamped), low samples = 64.
- ch0 mode 1, freq=0x1000000, gain 128 -> out 0,32,64,…,224,255,223,…,31 sequence; peak 255 at p=0x7F8.
- SWEEP_DIV=4, ch0 freq=0x100000, step=0x100000, limit=0x300000, sweep_en=1, update -> active freq 0x100000,0x200000,0x300000,0x100000, each step after 4 cycles. Update coincident with a tick restarts at the start value.
